pixel_shadow_reader: RTL and testbench

Read-side companion to the sprite drawers: snoops the same `plot`/`x`/`y`/`colour` pixel-write stream sent to the VGA adapter and mirrors it into a shadow frame memory. On request, it reads back the 2x2 region under the player's position and reports whether any pixel there carries the hazard (car) colour. Sits beside the VGA adapter on the shared pixel bus; its `hit` result feeds the game-control FSM for collision and reset-to-start decisions.

---
 rtl/pixel_shadow_reader.sv | 167 ++++++++++++++++
 tb/tb_pixel_shadow_reader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_shadow_reader.sv
// Shadow frame memory fed by the pixel-write bus; answers 2x2 hazard-colour queries (PIXEL_SHADOW_FULL_COLOUR_EN keeps full colour).
// Query done 6 cycles after accept (+1 per plot stall); requests while busy are dropped, plot writes always win the port.
module pixel_shadow_reader #(
  parameter int          X_MAX         = 160,
  parameter int          Y_MAX         = 120,
  parameter logic [2:0]  HAZARD_COLOUR = 3'b100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       clear_req,
  input  logic       query_req,
  input  logic [7:0] qx,
  input  logic [6:0] qy,
  output logic       busy,
  output logic       done,
  output logic       hit,
  output logic [2:0] hit_colour
);

  localparam int          DEPTH   = X_MAX * Y_MAX;
  localparam logic [14:0] DEPTH_W = 15'(DEPTH);
  localparam logic [8:0]  X_LIM   = 9'(X_MAX);
  localparam logic [7:0]  Y_LIM   = 8'(Y_MAX);

`ifdef PIXEL_SHADOW_FULL_COLOUR_EN
  localparam int DW = 3;
`else
  localparam int DW = 1;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_QUERY = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [14:0]   clr_cnt;
  logic [2:0]    k;
  logic [7:0]    q_x;
  logic [6:0]    q_y;
  logic          cmp_vld;
  logic          cmp_on;
  logic          cmp_last;

  logic          plot_vld;
  logic [8:0]    cx;
  logic [7:0]    cy;
  logic          on_screen;
  logic          issue;
  logic          mem_we;
  logic          mem_re;
  logic [14:0]   mem_addr;
  logic [DW-1:0] mem_wdat;
  logic [DW-1:0] plot_dat;
  logic [DW-1:0] rd_dat;
  logic          px_match;
  logic [2:0]    px_colour;

  logic [DW-1:0] mem [DEPTH];

  // Widened operands keep y*X_MAX+x exact across the full 15-bit range.
  function automatic logic [14:0] pix_addr(input logic [8:0] px, input logic [7:0] py);
    return 15'(py) * 15'(X_MAX) + 15'(px);
  endfunction

`ifdef PIXEL_SHADOW_FULL_COLOUR_EN
  assign plot_dat  = colour;
  assign px_match  = (rd_dat == HAZARD_COLOUR);
  assign px_colour = rd_dat;
`else
  assign plot_dat  = (colour == HAZARD_COLOUR);
  assign px_match  = rd_dat[0];
  assign px_colour = 3'd0;
`endif

  assign plot_vld  = plot && ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
  assign cx        = {1'b0, q_x} + {8'd0, k[0]};
  assign cy        = {1'b0, q_y} + {7'd0, k[1]};
  assign on_screen = (cx < X_LIM) && (cy < Y_LIM);
  assign issue     = (state == S_QUERY) && !k[2] && !plot_vld;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // Single memory port: plot write, then clear write, then query read.
  always_comb begin
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = pix_addr({1'b0, x}, {1'b0, y});
    mem_wdat = plot_dat;
    if (plot_vld) begin
      mem_we = 1'b1;
    end else if (state == S_CLEAR && clr_cnt != DEPTH_W) begin
      mem_we   = 1'b1;
      mem_addr = clr_cnt;
      mem_wdat = '0;
    end else if (issue && on_screen) begin
      mem_re   = 1'b1;
      mem_addr = pix_addr(cx, cy);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_addr] <= mem_wdat;
    if (mem_re)
      rd_dat <= mem[mem_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      clr_cnt    <= '0;
      k          <= '0;
      q_x        <= '0;
      q_y        <= '0;
      cmp_vld    <= 1'b0;
      cmp_on     <= 1'b0;
      cmp_last   <= 1'b0;
      hit        <= 1'b0;
      hit_colour <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear_req) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
          end else if (query_req) begin
            state      <= S_QUERY;
            q_x        <= qx;
            q_y        <= qy;
            k          <= '0;
            cmp_vld    <= 1'b0;
            hit        <= 1'b0;
            hit_colour <= 3'd0;
          end
        end
        S_CLEAR: begin
          if (clr_cnt == DEPTH_W)
            state <= S_IDLE;
          else if (!plot_vld)
            clr_cnt <= clr_cnt + 15'd1;
        end
        S_QUERY: begin
          cmp_vld  <= issue;
          cmp_on   <= on_screen;
          cmp_last <= (k == 3'd3);
          if (issue)
            k <= k + 3'd1;
          // Off-screen slots still take a compare cycle but never match.
          if (cmp_vld && cmp_on && px_match) begin
            hit <= 1'b1;
            if (!hit)
              hit_colour <= px_colour;
          end
          if (cmp_vld && cmp_last)
            state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_shadow_reader.sv
// Scoreboarded bench for pixel_shadow_reader: query results and latencies queued at stimulus, checked on done.
module tb_pixel_shadow_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       clear_req;
  logic       query_req;
  logic [7:0] qx;
  logic [6:0] qy;
  logic       busy;
  logic       done;
  logic       hit;
  logic [2:0] hit_colour;

  int tests = 0;
  int fails = 0;

  localparam int CLEAR_CYCLES = 160 * 120 + 1;

`ifdef PIXEL_SHADOW_FULL_COLOUR_EN
  localparam logic [2:0] HIT_HC = 3'b100;
`else
  localparam logic [2:0] HIT_HC = 3'b000;
`endif

  typedef struct {
    logic       hit;
    logic [2:0] hc;
    int         lat;
  } exp_t;

  exp_t sb[$];

  pixel_shadow_reader dut (
    .clk        (clk),
    .reset      (reset),
    .plot       (plot),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .clear_req  (clear_req),
    .query_req  (query_req),
    .qx         (qx),
    .qy         (qy),
    .busy       (busy),
    .done       (done),
    .hit        (hit),
    .hit_colour (hit_colour)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic plot_pixel(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
    x = px; y = py; colour = pc; plot = 1'b1;
    tick();
    plot = 1'b0;
  endtask

  // Runs one query; optional plot burst on cycles s_start..s_start+s_len-1 after accept.
  task automatic run_query(input string name, input logic [7:0] ax, input logic [6:0] ay,
                           input logic eh, input int elat, input int s_start, input int s_len,
                           input logic [7:0] sx, input logic [6:0] sy, input logic [2:0] sc);
    exp_t e;
    exp_t got_e;
    int   lat;
    logic got;
    e.hit = eh;
    e.hc  = eh ? HIT_HC : 3'd0;
    e.lat = elat;
    sb.push_back(e);
    qx = ax; qy = ay; query_req = 1'b1;
    tick();
    query_req = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL %s_accept: busy=%0b expected 1", name, busy);
    end
    lat = 1;
    got = 1'b0;
    while (!got && lat < 40) begin
      plot = (lat >= s_start) && (lat < s_start + s_len);
      x = sx; y = sy; colour = sc;
      if (done === 1'b1) got = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    plot = 1'b0;
    got_e = sb.pop_front();
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s_timeout: no done within %0d cycles, expected at %0d", name, lat, got_e.lat);
    end else begin
      if (lat !== got_e.lat) begin
        fails++;
        $display("FAIL %s_latency: done at cycle %0d expected %0d", name, lat, got_e.lat);
      end
      tests++;
      if (hit !== got_e.hit) begin
        fails++;
        $display("FAIL %s_hit: hit=%0b expected %0b", name, hit, got_e.hit);
      end
      tests++;
      if (hit_colour !== got_e.hc) begin
        fails++;
        $display("FAIL %s_hit_colour: hit_colour=%0d expected %0d", name, hit_colour, got_e.hc);
      end
    end
    tick();
  endtask

  task automatic run_clear(input string name);
    int n;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < CLEAR_CYCLES + 50) begin
      tick();
      n++;
    end
    tests++;
    if (n !== CLEAR_CYCLES) begin
      fails++;
      $display("FAIL %s_cycles: busy high for %0d cycles expected %0d", name, n, CLEAR_CYCLES);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: busy=%0b expected 0", busy); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: done=%0b expected 0", done); end
    tests++;
    if (hit !== 1'b0) begin fails++; $display("FAIL reset_hit: hit=%0b expected 0", hit); end
    tests++;
    if (hit_colour !== 3'd0) begin
      fails++;
      $display("FAIL reset_hit_colour: hit_colour=%0d expected 0", hit_colour);
    end
  endtask

  task automatic test_reset_mid_clear();
    plot_pixel(8'd5, 7'd5, 3'b100);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL abort_clear_busy: busy=%0b expected 0", busy); end
    run_clear("full_clear");
    run_query("cleared", 8'd5, 7'd5, 1'b0, 6, 0, 0, 8'd0, 7'd0, 3'd0);
  endtask

  task automatic test_hazard_hit();
    plot_pixel(8'd50, 7'd40, 3'b100);
    run_query("hazard", 8'd49, 7'd39, 1'b1, 6, 0, 0, 8'd0, 7'd0, 3'd0);
    repeat (3) tick();
    tests++;
    if (hit !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL sticky_hit: hit=%0b done=%0b expected hit=1 done=0", hit, done);
    end
  endtask

  task automatic test_no_hazard();
    plot_pixel(8'd50, 7'd40, 3'b010);
    run_query("safe_colour", 8'd50, 7'd40, 1'b0, 6, 0, 0, 8'd0, 7'd0, 3'd0);
  endtask

  task automatic test_corner();
    plot_pixel(8'd159, 7'd119, 3'b100);
    run_query("corner", 8'd159, 7'd119, 1'b1, 6, 0, 0, 8'd0, 7'd0, 3'd0);
  endtask

  task automatic test_stall();
    plot_pixel(8'd11, 7'd11, 3'b100);
    run_query("stall", 8'd10, 7'd10, 1'b1, 9, 2, 3, 8'd80, 7'd60, 3'b100);
    run_query("stall_write", 8'd80, 7'd60, 1'b1, 6, 0, 0, 8'd0, 7'd0, 3'd0);
  endtask

  task automatic test_oob_write();
    plot_pixel(8'd200, 7'd0, 3'b100);
    run_query("oob_query", 8'd199, 7'd0, 1'b0, 6, 0, 0, 8'd0, 7'd0, 3'd0);
    run_query("oob_alias", 8'd40, 7'd1, 1'b0, 6, 0, 0, 8'd0, 7'd0, 3'd0);
  endtask

  task automatic test_reset_mid_query();
    int pulses;
    qx = 8'd49; qy = 7'd39; query_req = 1'b1;
    tick();
    query_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (busy !== 1'b0 || hit !== 1'b0) begin
      fails++;
      $display("FAIL abort_query: busy=%0b hit=%0b expected 0 0", busy, hit);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    tests++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL abort_query_done: %0d done pulses expected 0", pulses);
    end
  endtask

  initial begin
    reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
    clear_req = 1'b0; query_req = 1'b0; qx = '0; qy = '0;
    test_reset();
    test_reset_mid_clear();
    test_hazard_hit();
    test_no_hazard();
    test_corner();
    test_stall();
    test_oob_write();
    test_reset_mid_query();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
